// File: rtl/serial_arith_unit.sv
// Bit-serial add/subtract/transfer/decrement unit: one full-adder slice, LSB first.
// Latency WIDTH+1 cycles from accepting edge to done; start is ignored while busy.
module serial_arith_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [1:0]       op;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             load, last, b_bit, sum_bit, carry_nxt;

  // Operand B as seen by the slice, selected by the latched op code.
  always_comb begin
    b_bit = b_sh[0];
    case (op)
      2'b00:   b_bit = b_sh[0];
      2'b01:   b_bit = ~b_sh[0];
      2'b10:   b_bit = 1'b0;
      default: b_bit = 1'b1;
    endcase
    sum_bit   = a_sh[0] ^ b_bit ^ carry;
    carry_nxt = (a_sh[0] & b_bit) | (a_sh[0] & carry) | (b_bit & carry);
    last      = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // s keeps the previous result across the load edge; it only starts shifting in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      op    <= 2'b00;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      op    <= {s1, s0};
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= carry_nxt;
      cnt   <= cnt + CW'(1);
      s     <= {sum_bit, s[WIDTH-1:1]};
      if (last) cout <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_serial_arith_unit.sv
// Scoreboard bench: stimulus pushes arithmetic-model results, a monitor pops on done.
module tb_serial_arith_unit;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, s1 = 1'b0, s0 = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout;
  logic [W-1:0] s;

  int vectors = 0;
  int miscompares = 0;
  logic [W:0] exp_q[$];

  serial_arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .s1(s1), .s0(s0),
    .a(a), .b(b), .cin(cin), .busy(busy), .done(done), .s(s), .cout(cout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input int op, input int av, input int bv, input int c);
    int opb;
    case (op)
      0:       opb = bv;
      1:       opb = (~bv) & MASK;
      2:       opb = 0;
      default: opb = MASK;
    endcase
    return (W+1)'(av + opb + c);
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", int'({cout, s}), int'(e));
      end
    end
  end

  // Called at a negedge; returns at the negedge of the DONE cycle with start=0.
  task automatic run_op(input int op, input int av, input int bv, input int c, input bit hold);
    {s1, s0} = 2'(op);
    a = W'(av); b = W'(bv); cin = c[0];
    start = 1'b1;
    exp_q.push_back(model(op, av, bv, c));
    @(posedge clk); #1;
    start = hold;
    for (int i = 0; i < W; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); {s1, s0} = 2'($urandom);
      @(negedge clk);
      check("busy_run", int'({busy, done}), 2);
    end
    @(negedge clk);
    check("done_cycle", int'({busy, done}), 1);
    start = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_outputs", int'({busy, done, cout, s}), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", int'({busy, done, cout, s}), 0);

    run_op(0, 4'b0101, 4'b0011, 0, 1'b0);
    check("hold_after_done", int'({cout, s}), 5'b01000);
    @(negedge clk);
    check("back_to_idle", int'({busy, done}), 0);
    run_op(1, 4'b0111, 4'b0010, 1, 1'b0);
    run_op(2, 4'b1111, $urandom_range(0, MASK), 1, 1'b0);
    run_op(3, 4'b0000, $urandom_range(0, MASK), 0, 1'b0);
    run_op(0, 4'b0110, 4'b1011, 1, 1'b1);
    // Chained from the DONE cycle.
    run_op(0, 4'b0001, 4'b0001, 0, 1'b0);

    // Reset during the second RUN cycle.
    @(negedge clk);
    {s1, s0} = 2'b00; a = 4'b1111; b = 4'b1111; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1 check("async_abort", int'({busy, done, cout, s}), 0);
    @(negedge clk); @(negedge clk);
    check("held_in_reset", int'({busy, done, cout, s}), 0);
    rst = 1'b0;
    @(negedge clk);
    run_op(0, 4'b1001, 4'b0111, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op($urandom_range(0, 3), $urandom_range(0, MASK), $urandom_range(0, MASK),
             $urandom_range(0, 1), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        int gap;
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) @(negedge clk);
        check("idle_gap", int'({busy, done}), 0);
      end
    end

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
